// File: rtl/poly1305_seq_if.sv
// Bus bundle between the Poly1305 message sequencer, its key/message/tag
// clients and the external Poly1305 block core.
interface poly1305_seq_if;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] key_r;
  logic [127:0] key_s;

  logic         msg_valid;
  logic         msg_ready;
  logic [127:0] msg_data;
  logic [4:0]   msg_bytes;
  logic         msg_last;

  logic [127:0] core_r;
  logic [127:0] core_s;
  logic [127:0] core_m;
  logic         core_fb;
  logic         core_ld;
  logic         core_first;
  logic         core_rdy;
  logic [127:0] core_p;

  logic [127:0] tag;
  logic         tag_valid;
  logic         tag_ready;
  logic         abort;
  logic         err;
  logic [31:0]  blk_cnt;

  modport slave (
    input  key_valid, key_r, key_s,
    output key_ready,
    input  msg_valid, msg_data, msg_bytes, msg_last,
    output msg_ready,
    output core_r, core_s, core_m, core_fb, core_ld, core_first,
    input  core_rdy, core_p,
    output tag, tag_valid, err, blk_cnt,
    input  tag_ready, abort
  );

  modport master (
    output key_valid, key_r, key_s,
    input  key_ready,
    output msg_valid, msg_data, msg_bytes, msg_last,
    input  msg_ready,
    input  core_r, core_s, core_m, core_fb, core_ld, core_first,
    output core_rdy, core_p,
    input  tag, tag_valid, err, blk_cnt,
    output tag_ready, abort
  );
endinterface

// File: rtl/poly1305_seq.sv
// Poly1305 message sequencer: takes a key, pads and issues 16-byte blocks to
// the block core one at a time, and returns the final accumulator as the tag.
//
// state    | meaning
// IDLE     | waiting for a key handshake
// WAIT_MSG | ready to accept the next message beat
// ISSUE    | core_ld pulse for the latched block
// BUSY     | waiting for the core to finish the block
// TAG      | presenting tag until tag_ready
module poly1305_seq (
  input  logic           clk,
  input  logic           reset,
  poly1305_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_MSG = 3'd1,
    ISSUE    = 3'd2,
    BUSY     = 3'd3,
    TAG      = 3'd4
  } state_t;

  state_t       state, state_nxt;
  logic         key_acc, beat_acc, beat_empty, beat_bad;
  logic         rdy_done, rdy_stray, blk_inc;
  logic         first_pend, last_q;
  logic [127:0] m_pad;

  // Handshake outputs decode only the registered state.
  assign bus.key_ready = (state == IDLE);
  assign bus.msg_ready = (state == WAIT_MSG);
  assign bus.core_ld   = (state == ISSUE);
  assign bus.tag_valid = (state == TAG);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    key_acc    = 1'b0;
    beat_acc   = 1'b0;
    beat_empty = 1'b0;
    beat_bad   = 1'b0;
    rdy_done   = 1'b0;
    rdy_stray  = 1'b0;
    blk_inc    = 1'b0;
    if (bus.abort) begin
      state_nxt = IDLE;
    end else begin
      rdy_stray = bus.core_rdy && (state != BUSY);
      case (state)
        IDLE: begin
          if (bus.key_valid) begin
            key_acc   = 1'b1;
            state_nxt = WAIT_MSG;
          end
        end
        WAIT_MSG: begin
          if (bus.msg_valid) begin
            if (bus.msg_bytes == 5'd0 && bus.msg_last && first_pend) begin
              beat_empty = 1'b1;
              state_nxt  = TAG;
            end else if (bus.msg_bytes == 5'd0 || bus.msg_bytes > 5'd16) begin
              beat_bad = 1'b1;
            end else begin
              beat_acc  = 1'b1;
              state_nxt = ISSUE;
            end
          end
        end
        ISSUE: begin
          blk_inc   = 1'b1;
          state_nxt = BUSY;
        end
        BUSY: begin
          if (bus.core_rdy) begin
            rdy_done  = 1'b1;
            state_nxt = last_q ? TAG : WAIT_MSG;
          end
        end
        TAG: begin
          if (bus.tag_ready) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Short blocks get a 0x01 terminator byte right after the data; a full
  // block copies every byte and relies on core_fb for the high bit instead.
  always_comb begin
    m_pad = '0;
    for (int i = 0; i < 16; i++) begin
      if (5'(i) < bus.msg_bytes)
        m_pad[8*i +: 8] = bus.msg_data[8*i +: 8];
      else if (5'(i) == bus.msg_bytes)
        m_pad[8*i +: 8] = 8'h01;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.core_r     <= '0;
      bus.core_s     <= '0;
      bus.core_m     <= '0;
      bus.core_fb    <= 1'b0;
      bus.core_first <= 1'b0;
      bus.tag        <= '0;
      bus.err        <= 1'b0;
      bus.blk_cnt    <= '0;
      first_pend     <= 1'b0;
      last_q         <= 1'b0;
    end else begin
      if (key_acc) begin
        bus.core_r  <= bus.key_r;
        bus.core_s  <= bus.key_s;
        bus.blk_cnt <= '0;
        bus.err     <= 1'b0;
        first_pend  <= 1'b1;
      end
      if (beat_acc) begin
        bus.core_m     <= m_pad;
        bus.core_fb    <= (bus.msg_bytes == 5'd16);
        bus.core_first <= first_pend;
        last_q         <= bus.msg_last;
      end
      if (blk_inc)
        bus.blk_cnt <= bus.blk_cnt + 32'd1;
      if (rdy_done) begin
        first_pend <= 1'b0;
        if (last_q) bus.tag <= bus.core_p;
      end
      if (beat_empty)
        bus.tag <= bus.core_s;
      if (beat_bad || rdy_stray)
        bus.err <= 1'b1;
      if (bus.abort)
        bus.blk_cnt <= '0;
    end
  end

endmodule

// File: doc/poly1305_seq.md
POLY1305_SEQ -- requirements
Module: poly1305_seq

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-003 SHALL have ports: key_valid input 1, key_ready output 1, key_r input 128, key_s input 128 -- one-time key handshake per message.
REQ-004 SHALL have ports: msg_valid input 1, msg_ready output 1, msg_data input 128 (byte 0 in bits 7:0), msg_bytes input 5 (0..16), msg_last input 1 -- message beat handshake.
REQ-005 SHALL have ports: core_r output 128, core_s output 128, core_m output 128, core_fb output 1, core_ld output 1, core_first output 1 -- drive the Poly1305 block core.
REQ-006 SHALL have ports: core_rdy input 1 (one-cycle block-done pulse), core_p input 128 (acc_out + s, valid in core_rdy cycle).
REQ-007 SHALL have ports: tag output 128, tag_valid output 1, tag_ready input 1, abort input 1, err output 1 (sticky protocol error), blk_cnt output 32 (blocks issued this message).

Function
REQ-008 SHALL implement states IDLE, WAIT_MSG, ISSUE, BUSY, TAG.
REQ-009 IDLE: key_ready=1; key_valid=1 -> latch key_r/key_s into core_r/core_s, set first_pend=1, clear blk_cnt, go WAIT_MSG next cycle.
REQ-010 WAIT_MSG: msg_ready=1; accepted beat (msg_valid&msg_ready) -> latch beat, go ISSUE; all other states msg_ready=0.
REQ-011 Beat with msg_bytes=16: core_m=msg_data, core_fb=1.
REQ-012 Beat with msg_bytes=n, 1..15: core_m bytes 0..n-1 = msg_data bytes, byte n = 0x01, bytes n+1..15 = 0x00, core_fb=0.
REQ-013 ISSUE: core_ld=1 for exactly one cycle, core_first=first_pend, blk_cnt increments by 1 (wraps at 2^32-1 to 0), go BUSY.
REQ-014 core_m, core_fb, core_first SHALL be held constant from the ISSUE cycle through the core_rdy cycle inclusive.
REQ-015 BUSY: on core_rdy, clear first_pend; if latched beat was last -> capture core_p into tag, go TAG; else go WAIT_MSG.
REQ-016 Latency: beat accepted in cycle T -> core_ld in T+1; core_rdy in cycle R -> msg_ready or tag_valid high in R+1.
REQ-017 TAG: tag_valid=1, tag stable until tag_valid&tag_ready; then go IDLE next cycle.
REQ-018 Empty message: msg_bytes=0 with msg_last=1 while first_pend=1 -> no core_ld, tag=core_s, go TAG next cycle.
REQ-019 msg_bytes=0 in any other case, or msg_bytes>16 -> beat consumed, dropped, err set to 1, stay WAIT_MSG.
REQ-020 core_rdy outside BUSY SHALL be ignored and set err.
REQ-021 abort=1 in any state -> go IDLE next cycle, core_ld/tag_valid deassert, blk_cnt cleared, err unchanged; abort has priority over all other events in that cycle.
REQ-022 err SHALL clear only on reset or on an accepted key handshake.
REQ-023 core_ld, key_ready, msg_ready, tag_valid SHALL be registered-state-decoded (no combinational path from msg_valid/tag_ready/core_rdy).

Reset
REQ-024 reset=0 SHALL immediately force state IDLE, core_ld=0, core_fb=0, core_first=0, tag_valid=0, msg_ready=0, err=0, blk_cnt=0, core_r/core_s/core_m/tag=0, first_pend=0.
REQ-025 key_ready SHALL be 1 from the first clock after reset release (IDLE decode).
REQ-026 Reset asserted mid-BUSY SHALL discard the block; no tag produced.

Verification
REQ-027 Key r=0x..,s=0x0 then one 16-byte beat, last -> single core_ld with core_first=1, core_fb=1; core_rdy with core_p=X -> tag=X, tag_valid next cycle, blk_cnt=1.
REQ-028 Three beats (16,16,5 bytes, last on third) -> three core_ld pulses, core_first only on first; third core_m byte5=0x01, bytes 6..15=0, core_fb=0; blk_cnt=3.
REQ-029 Empty message (msg_bytes=0, last, first beat) with s=0x1234 -> tag=0x1234 one cycle later, no core_ld.
REQ-030 msg_bytes=0 on second beat and msg_bytes=17 -> err=1, beats dropped, no core_ld, state stays WAIT_MSG; next key handshake clears err.
REQ-031 abort during BUSY, then stray core_rdy in IDLE -> IDLE, no tag_valid, err=1.
REQ-032 tag_ready held low 10 cycles -> tag_valid and tag stable all 10 cycles, msg_ready=0, key_ready=0; reset=0 mid-BUSY -> all outputs to REQ-024 values asynchronously.
